systolic_array: RTL and testbench
=================================

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 SHALL have parameter SIZE, default 14: input frame width/height in samples, legal range 3..255.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset; the codebase port name is kept, but it is synchronous and active-high (1 = reset).
REQ-004 SHALL have port w_load  input  1: weight-stream qualifier.
REQ-005 SHALL have port i_load  input  1: input-stream qualifier.
REQ-006 SHALL have port w_in  input  16: signed weight sample.
REQ-007 SHALL have port i_in  input  16: signed input-pixel sample.
REQ-008 SHALL have port result  output  16: signed convolution output, registered.
REQ-009 SHALL have port res_sig  output  1: result-valid strobe, registered.

Function
REQ-010 SHALL use a fixed 3x3 kernel: weights w[0..8], stored row-major.
REQ-011 SHALL accept one weight per cycle while w_load=1; sample k of a w_load assertion goes to w[k], k=0..8.
REQ-012 SHALL ignore further weight samples once 9 have been taken; the count restarts at 0 after w_load has been 0 for at least one cycle.
REQ-013 SHALL accept one pixel per cycle while i_load=1, in row-major order x[r][c], r,c in 0..SIZE-1.
REQ-014 SHALL ignore pixels after SIZE*SIZE have been accepted; the frame count restarts at 0 after i_load has been 0 for at least one cycle.
REQ-015 SHALL give w_load priority: while w_load=1, i_in is ignored and the frame count does not advance.
REQ-016 SHALL compute valid (no-padding) outputs y[r][c] = sum over i,j in 0..2 of w[3i+j]*x[r+i][c+j], for r,c in 0..SIZE-3.
REQ-017 SHALL implement REQ-016 with two SIZE-deep line buffers plus a 3x3 window register array; full-frame storage is not allowed.
REQ-018 SHALL form 32-bit signed products and a 32-bit signed sum; without the macro, result = low 16 bits of the sum (two's-complement wrap).
REQ-019 SHALL update result and set res_sig=1 on the rising edge that follows acceptance of pixel x[r+2][c+2] (latency 1 cycle).
REQ-020 SHALL hold res_sig=1 for exactly one cycle per output and keep it 0 while the window straddles a row boundary (column index < 2) and while rows 0..1 fill.
REQ-021 SHALL produce exactly (SIZE-2)^2 strobes per frame, in row-major output order.
REQ-022 SHALL hold result at its last value when res_sig=0.
REQ-023 SHALL not clear weights at the start of a new frame; the weights are reused across frames.

Reset
REQ-024 SHALL, when rst_n=1 at a clock edge, clear weights, line buffers, window, counters, result (0) and res_sig (0).
REQ-025 SHALL abort an in-progress weight load or frame on reset; no strobe is produced for an aborted frame.
REQ-026 SHALL give reset priority over w_load and i_load in the same cycle.

Configuration
REQ-027 SHALL, when macro SYS_ARRAY_SAT_EN is defined, saturate the 32-bit sum to [-32768, 32767] instead of wrapping.
REQ-028 SHALL, when SYS_ARRAY_SAT_EN is undefined, wrap as in REQ-018; all other behaviour is identical.

Verification
REQ-029 SHALL pass this test: SIZE=14; weights 1..9 via w_load; pixels 0..195 row-major via i_load -> 144 strobes, first result 933, second 978, general y[r][c] = 933+45*(14r+c), last result 8358.
REQ-030 SHALL pass this test: first pixel-frame sample in cycle t -> first res_sig in cycle t+31 (pixel x[2][2] is sample 30); strobes gap 3 cycles at each row wrap.
REQ-031 SHALL pass this test: w_load held 50 cycles with a wrapping 0..8 stream of values 1..9 -> weights equal 1..9 (extra samples ignored); i_load held 250 cycles -> still exactly 144 strobes.
REQ-032 SHALL pass this test: rst_n=1 for one cycle mid-frame (after 100 pixels) -> res_sig=0, result=0; a following full frame with all pixels =1 gives results 0, because weights are cleared.
REQ-033 SHALL pass this test: weights all 32767, pixels all 32767 -> results are the wrapped low 16 bits without the macro, and 32767 with SYS_ARRAY_SAT_EN.
REQ-034 SHALL pass this test: w_load and i_load both 1 for 5 cycles -> pixels are ignored and the frame count stays 0.

Source files
------------

// File: rtl/systolic_array.sv
// 3x3 valid-mode convolution over a SIZE x SIZE row-major pixel stream.
// Define SYS_ARRAY_SAT_EN to saturate the output instead of wrapping it.
module systolic_array #(
  parameter int SIZE = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_load,
  input  logic               i_load,
  input  logic signed [15:0] w_in,
  input  logic signed [15:0] i_in,
  output logic signed [15:0] result,
  output logic               res_sig
);

  localparam int AW = $clog2(SIZE);

  logic signed [15:0] w_q [9];
  logic [3:0]         wcnt_q;
  logic [AW-1:0]      row_q;
  logic [AW-1:0]      col_q;
  logic               done_q;
  logic signed [15:0] lb0_q [SIZE];
  logic signed [15:0] lb1_q [SIZE];
  logic signed [15:0] win_q [3][2];
  logic signed [15:0] col_d [3];
  logic signed [31:0] sum_d;
  logic signed [15:0] res_d;
  logic               acc;
  logic               vld_d;

  assign acc   = i_load && !w_load && !done_q;
  assign vld_d = acc && (row_q >= AW'(2)) && (col_q >= AW'(2));

  // Rightmost window column comes straight from the line buffers and i_in,
  // so the result can register on the same edge that accepts the pixel.
  always_comb begin
    col_d[0] = lb0_q[col_q];
    col_d[1] = lb1_q[col_q];
    col_d[2] = i_in;
  end

  always_comb begin
    logic signed [31:0] a;
    logic signed [31:0] b;
    sum_d = '0;
    a     = '0;
    b     = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        a = w_q[3*i+j];
        b = (j == 2) ? col_d[i] : win_q[i][j];
        sum_d = sum_d + a * b;
      end
    end
  end

  always_comb begin
`ifdef SYS_ARRAY_SAT_EN
    if (sum_d > 32767)
      res_d = 16'sh7fff;
    else if (sum_d < -32768)
      res_d = 16'sh8000;
    else
      res_d = sum_d[15:0];
`else
    res_d = sum_d[15:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
      for (int k = 0; k < SIZE; k++) begin
        lb0_q[k] <= '0;
        lb1_q[k] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= '0;
        win_q[i][1] <= '0;
      end
      wcnt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      result  <= '0;
      res_sig <= 1'b0;
    end else begin
      if (!w_load) begin
        wcnt_q <= '0;
      end else if (wcnt_q != 4'd9) begin
        w_q[wcnt_q] <= w_in;
        wcnt_q      <= wcnt_q + 4'd1;
      end

      if (!i_load) begin
        row_q  <= '0;
        col_q  <= '0;
        done_q <= 1'b0;
      end else if (acc) begin
        lb0_q[col_q] <= lb1_q[col_q];
        lb1_q[col_q] <= i_in;
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= col_d[i];
        end
        if (col_q == AW'(SIZE-1)) begin
          col_q <= '0;
          if (row_q == AW'(SIZE-1))
            done_q <= 1'b1;
          else
            row_q <= row_q + AW'(1);
        end else begin
          col_q <= col_q + AW'(1);
        end
      end

      res_sig <= vld_d;
      if (vld_d)
        result <= res_d;
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: frame table plus reset/priority sequences,
// each checked against a direct-formula convolution model.
module tb_systolic_array;

  localparam int S = 14;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               w_load;
  logic               i_load;
  logic signed [15:0] w_in;
  logic signed [15:0] i_in;
  logic signed [15:0] result;
  logic               res_sig;

  always #5 clk = ~clk;

  systolic_array #(.SIZE(S)) dut (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .i_load(i_load),
    .w_in(w_in), .i_in(i_in), .result(result), .res_sig(res_sig)
  );

  typedef struct {
    bit          wl;
    bit          il;
    logic [15:0] w;
    logic [15:0] x;
  } cyc_t;

  typedef struct {
    int wmode;
    int pmode;
    int wcyc;
    int pcyc;
    int exp_first;
    int exp_last;
    bit has_exp;
  } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   wm [9];
  cyc_t stim [$];
  int   got_v [$];
  int   got_t [$];
  int   exp_v [$];
  int   exp_t [$];

`ifdef SYS_ARRAY_SAT_EN
  localparam int SATV = 32767;
`else
  localparam int SATV = 9;
`endif

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int fold(int s);
`ifdef SYS_ARRAY_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    return int'(shortint'(s));
`endif
  endfunction

  function automatic cyc_t mk(bit wl, bit il, int w, int x);
    cyc_t c;
    c.wl = wl;
    c.il = il;
    c.w  = w[15:0];
    c.x  = x[15:0];
    return c;
  endfunction

  function automatic int wval(int mode, int k);
    case (mode)
      0:       return k % 9 + 1;
      1:       return 32767;
      2:       return -1;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  function automatic int pval(int mode, int k);
    case (mode)
      0:       return k;
      1:       return 32767;
      2:       return 100;
      4:       return 1;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  // Expected outputs straight from the convolution formula over the
  // accepted pixels; stamped with the stimulus index of the last pixel.
  function automatic void model();
    int px [S*S];
    int wc = 0;
    int n  = 0;
    exp_v.delete();
    exp_t.delete();
    foreach (px[q]) px[q] = 0;
    for (int k = 0; k < stim.size(); k++) begin
      if (stim[k].wl) begin
        if (wc < 9) wm[wc] = int'($signed(stim[k].w));
        wc++;
      end else begin
        wc = 0;
      end
      if (stim[k].il && !stim[k].wl && n < S*S) begin
        int r = n / S;
        int c = n % S;
        px[n] = int'($signed(stim[k].x));
        if (r >= 2 && c >= 2) begin
          int s = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              s += wm[3*i+j] * px[(r-2+i)*S + c-2+j];
          exp_v.push_back(fold(s));
          exp_t.push_back(k);
        end
        n++;
      end
      if (!stim[k].il) n = 0;
    end
  endfunction

  task automatic run();
    model();
    got_v.delete();
    got_t.delete();
    for (int k = 0; k < stim.size(); k++) begin
      @(negedge clk);
      w_load = stim[k].wl;
      i_load = stim[k].il;
      w_in   = stim[k].w;
      i_in   = stim[k].x;
      @(posedge clk);
      #1;
      if (res_sig) begin
        got_v.push_back(int'(result));
        got_t.push_back(k);
      end
    end
    chk("strobe_count", got_v.size(), exp_v.size());
    for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
      chk($sformatf("y[%0d]", i), got_v[i], exp_v[i]);
      chk($sformatf("t[%0d]", i), got_t[i], exp_t[i]);
    end
  endtask

  task automatic build(int wmode, int pmode, int wcyc, int pcyc);
    stim.delete();
    for (int k = 0; k < wcyc; k++) stim.push_back(mk(1, 0, wval(wmode, k), 0));
    stim.push_back(mk(0, 0, 0, 0));
    for (int k = 0; k < pcyc; k++) stim.push_back(mk(0, 1, 0, pval(pmode, k)));
    for (int k = 0; k < 3; k++) stim.push_back(mk(0, 0, 0, 0));
  endtask

  initial begin
    vec_t tbl [5];
    int   p0;
    tbl[0] = '{0, 0, 9, 196, 933, 8358, 1};
    tbl[1] = '{0, 0, 50, 250, 933, 8358, 1};
    tbl[2] = '{1, 1, 9, 196, SATV, SATV, 1};
    tbl[3] = '{2, 2, 9, 196, -900, -900, 1};
    tbl[4] = '{3, 3, 9, 196, 0, 0, 0};

    foreach (wm[q]) wm[q] = 0;
    rst_n = 1'b1;
    w_load = 1'b0;
    i_load = 1'b0;
    w_in = '0;
    i_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res_sig", int'(res_sig), 0);
    chk("reset_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b0;

    foreach (tbl[v]) begin
      build(tbl[v].wmode, tbl[v].pmode, tbl[v].wcyc, tbl[v].pcyc);
      p0 = tbl[v].wcyc + 1;
      run();
      if (got_v.size() > 12) begin
        chk($sformatf("v%0d_latency", v), got_t[0] - p0, 30);
        chk($sformatf("v%0d_row_gap", v), got_t[12] - got_t[11], 3);
        if (tbl[v].has_exp) begin
          chk($sformatf("v%0d_first", v), got_v[0], tbl[v].exp_first);
          chk($sformatf("v%0d_last", v), got_v[got_v.size()-1], tbl[v].exp_last);
        end
        if (tbl[v].pmode == 0)
          chk($sformatf("v%0d_second", v), got_v[1], 978);
      end
    end

    // Mid-frame reset: weights must be wiped along with the frame.
    build(0, 0, 9, 0);
    run();
    stim.delete();
    for (int k = 0; k < 100; k++) stim.push_back(mk(0, 1, 0, k));
    run();
    @(negedge clk);
    rst_n  = 1'b1;
    w_load = 1'b1;
    i_load = 1'b1;
    w_in   = 16'sd5;
    @(posedge clk);
    #1;
    chk("midrst_res_sig", int'(res_sig), 0);
    chk("midrst_result", int'(result), 0);
    @(negedge clk);
    rst_n  = 1'b0;
    w_load = 1'b0;
    i_load = 1'b0;
    foreach (wm[q]) wm[q] = 0;
    @(posedge clk);
    #1;
    chk("abort_no_strobe", int'(res_sig), 0);
    build(0, 4, 0, 196);
    run();
    chk("ones_count", got_v.size(), 144);
    if (got_v.size() > 0)
      chk("ones_last", got_v[got_v.size()-1], 0);

    // w_load priority: pixels offered during weight load are dropped.
    stim.delete();
    for (int k = 0; k < 9; k++) stim.push_back(mk(1, 0, k + 1, 0));
    stim.push_back(mk(0, 0, 0, 0));
    for (int k = 0; k < 5; k++) stim.push_back(mk(1, 1, k + 1, 777));
    for (int k = 0; k < 196; k++) stim.push_back(mk(0, 1, 0, k));
    for (int k = 0; k < 3; k++) stim.push_back(mk(0, 0, 0, 0));
    run();
    chk("prio_count", got_v.size(), 144);
    if (got_v.size() > 0) begin
      chk("prio_first", got_v[0], 933);
      chk("prio_first_t", got_t[0], 45);
      chk("prio_last", got_v[got_v.size()-1], 8358);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
